pipe_ctrl: RTL

Pipeline control unit for the five-stage Y86 core. It watches the decode, execute, memory and write-back stage fields and drives the stall and bubble controls of the fetch, id_ex, ex_mem and mem_wb pipeline registers. It also gates condition-code updates and runs a halt state machine that freezes the pipeline on a non-AOK status. It sits beside the pipeline registers in the core top level; every pipeline register takes its stall/bubble inputs from this block.

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/pipe_perf_cnt.sv | 34 +++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the Y86 pipeline control unit: field widths, icodes,
// register/status encodings and the halt FSM state type.
package pipe_ctrl_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;

   // Instruction codes
   localparam logic [BYTE_W-1:0] IHALT   = 8'h00;
   localparam logic [BYTE_W-1:0] INOP    = 8'h01;
   localparam logic [BYTE_W-1:0] IRRMOVL = 8'h02;
   localparam logic [BYTE_W-1:0] IIRMOVL = 8'h03;
   localparam logic [BYTE_W-1:0] IRMMOVL = 8'h04;
   localparam logic [BYTE_W-1:0] IMRMOVL = 8'h05;
   localparam logic [BYTE_W-1:0] IOPL    = 8'h06;
   localparam logic [BYTE_W-1:0] IJXX    = 8'h07;
   localparam logic [BYTE_W-1:0] ICALL   = 8'h08;
   localparam logic [BYTE_W-1:0] IRET    = 8'h09;
   localparam logic [BYTE_W-1:0] IPUSHL  = 8'h0A;
   localparam logic [BYTE_W-1:0] IPOPL   = 8'h0B;

   // "No register" ID
   localparam logic [BYTE_W-1:0] RNONE   = 8'h0F;

   // Stage status codes
   localparam logic [BYTE_W-1:0] SAOK    = 8'h01;
   localparam logic [BYTE_W-1:0] SHLT    = 8'h02;
   localparam logic [BYTE_W-1:0] SADR    = 8'h03;
   localparam logic [BYTE_W-1:0] SINS    = 8'h04;

   typedef enum logic {
      PC_RUN    = 1'b0,
      PC_HALTED = 1'b1
   } pc_state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Three saturating performance counters with individual enables.
module pipe_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_cyc,
   input  logic             en_stall,
   input  logic             en_bubble,
   output logic [CNT_W-1:0] cnt_cyc,
   output logic [CNT_W-1:0] cnt_stall,
   output logic [CNT_W-1:0] cnt_bubble
);

   logic [CNT_W-1:0] cyc_q, stall_q, bubble_q;

   // Count enabled cycles, sticking at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_q    <= '0;
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (en_cyc    && (cyc_q    != '1)) cyc_q    <= cyc_q    + 1'b1;
         if (en_stall  && (stall_q  != '1)) stall_q  <= stall_q  + 1'b1;
         if (en_bubble && (bubble_q != '1)) bubble_q <= bubble_q + 1'b1;
      end
   end

   assign cnt_cyc    = cyc_q;
   assign cnt_stall  = stall_q;
   assign cnt_bubble = bubble_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage Y86 core: stall/bubble generation,
// condition-code gating and a halt FSM that freezes the pipe on a bad status.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] id_icode,
   input  logic [BYTE_W-1:0] id_srcA,
   input  logic [BYTE_W-1:0] id_srcB,
   input  logic [BYTE_W-1:0] ex_icode,
   input  logic [BYTE_W-1:0] ex_dstM,
   input  logic              ex_cnd,
   input  logic [BYTE_W-1:0] mem_icode,
   input  logic [BYTE_W-1:0] mem_stat,
   input  logic [BYTE_W-1:0] wb_stat,
   output logic              if_stall,
   output logic              id_stall,
   output logic              id_bubble,
   output logic              ex_bubble,
   output logic              mem_bubble,
   output logic              wb_stall,
   output logic              ex_set_cc,
   output logic              halted,
   output logic [BYTE_W-1:0] halt_stat
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]  perf_cyc,
   output logic [CNT_W-1:0]  perf_stall,
   output logic [CNT_W-1:0]  perf_bubble
`endif
);

   pc_state_e         state_q, state_d;
   logic [BYTE_W-1:0] halt_stat_q, halt_stat_d;
   logic              load_use, mispredict, ret_pend, exc_m, exc_w;

   // Hazard detection from the current stage fields
   always_comb begin
      load_use   = ((ex_icode == IMRMOVL) || (ex_icode == IPOPL)) && (ex_dstM != RNONE) &&
                   ((ex_dstM == id_srcA) || (ex_dstM == id_srcB));
      mispredict = (ex_icode == IJXX) && !ex_cnd;
      ret_pend   = (id_icode == IRET) || (ex_icode == IRET) || (mem_icode == IRET);
      exc_m      = (mem_stat != SAOK);
      exc_w      = (wb_stat != SAOK);
   end

   // Next state and pipeline-register controls; HALTED freezes everything
   always_comb begin
      state_d     = state_q;
      halt_stat_d = halt_stat_q;
      if_stall    = 1'b1;
      id_stall    = 1'b1;
      id_bubble   = 1'b0;
      ex_bubble   = 1'b0;
      mem_bubble  = 1'b1;
      wb_stall    = 1'b1;
      ex_set_cc   = 1'b0;
      unique case (state_q)
         PC_RUN: begin
            if_stall   = load_use | ret_pend;
            id_stall   = load_use;
            // Stall wins over bubble on the decode register
            id_bubble  = mispredict | (ret_pend & ~load_use);
            ex_bubble  = mispredict | load_use;
            mem_bubble = exc_m | exc_w;
            wb_stall   = exc_w;
            ex_set_cc  = (ex_icode == IOPL) & ~exc_m & ~exc_w;
            if (exc_w) begin
               state_d     = PC_HALTED;
               halt_stat_d = wb_stat;
            end
         end
         PC_HALTED: begin
            state_d = PC_HALTED;
         end
         default: begin
            state_d = PC_RUN;
         end
      endcase
   end

   // Halt FSM state and captured fault status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= PC_RUN;
         halt_stat_q <= SAOK;
      end else begin
         state_q     <= state_d;
         halt_stat_q <= halt_stat_d;
      end
   end

   assign halted    = (state_q == PC_HALTED);
   assign halt_stat = halt_stat_q;

`ifdef PIPE_CTRL_PERF_EN
   logic in_run;
   assign in_run = (state_q == PC_RUN);

   pipe_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk        (clk),
      .rst        (rst),
      .en_cyc     (in_run),
      .en_stall   (in_run & if_stall),
      .en_bubble  (in_run & (ex_bubble | id_bubble)),
      .cnt_cyc    (perf_cyc),
      .cnt_stall  (perf_stall),
      .cnt_bubble (perf_bubble)
   );
`endif

endmodule
